// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
// The master drives the byte and frame options; the slave returns the line and busy.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Each bit lasts Prescale clocks. TX_OUT and busy come directly from registers.
module uart_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_done;
    logic                      parity_bit;

    assign bit_done   = (cnt_q == presc_q - PRESCALE_WIDTH'(1));
    assign parity_bit = (^data_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        // Line level and busy are computed for the state being entered, so
        // both outputs change on the same edge as the state register.
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    presc_d   = (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference waveform plus a
// mid-bit sampling receiver model decode every transmitted frame.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) ifc ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, ifc.TX_OUT, 1'b1);
        check({tag, "_busy"}, ifc.busy, 1'b0);
    endtask

    // Called at a negedge with the transmitter idle. Drives one request and
    // checks every cycle of the frame against the bit list for that byte.
    // abort_at >= 0 asserts reset after that frame cycle instead of finishing.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input bit keep_dv,
                             input bit scramble, input int abort_at);
        int unsigned p;
        int unsigned nbits;
        logic        exp_bits[11];
        logic        rx[11];
        logic [7:0]  rx_byte;

        p     = (ps == 6'd0) ? 1 : int'(ps);
        nbits = pe ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        exp_bits[9]  = (^d) ^ pt;
        exp_bits[10] = 1'b1;
        exp_bits[nbits-1] = 1'b1;
        for (int i = 0; i < 11; i++) rx[i] = 1'b0;

        ifc.P_DATA     = d;
        ifc.PAR_EN     = pe;
        ifc.PAR_TYP    = pt;
        ifc.Prescale   = ps;
        ifc.Data_Valid = 1'b1;
        @(posedge clk);
        for (int unsigned k = 0; k < p * nbits; k++) begin
            @(negedge clk);
            if (!keep_dv) ifc.Data_Valid = 1'b0;
            check("tx_bit", ifc.TX_OUT, exp_bits[k/p]);
            check("busy_frame", ifc.busy, 1'b1);
            if (k % p == p / 2) rx[k/p] = ifc.TX_OUT;
            if (scramble) begin
                ifc.P_DATA   = 8'($urandom);
                ifc.PAR_EN   = 1'($urandom);
                ifc.PAR_TYP  = 1'($urandom);
                ifc.Prescale = 6'($urandom);
            end
            if (int'(k) == abort_at) begin
                rst = 1'b0;
                ifc.Data_Valid = 1'b0;
                @(negedge clk);
                check_idle("abort");
                rst = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check_idle("gap");

        for (int i = 0; i < 8; i++) rx_byte[i] = rx[i+1];
        check("rx_start", rx[0], 1'b0);
        check("rx_byte", rx_byte, d);
        if (pe) check("rx_parity", (^rx_byte) ^ rx[9], pt);
        check("rx_stop", rx[nbits-1], 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        ifc.P_DATA     = '0;
        ifc.Data_Valid = 1'b0;
        ifc.PAR_EN     = 1'b0;
        ifc.PAR_TYP    = 1'b0;
        ifc.Prescale   = 6'd8;

        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b1;
        repeat (50) begin
            @(negedge clk);
            check_idle("idle");
        end

        run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, -1);
        run_frame(8'h07, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, -1);
        run_frame(8'h07, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0, -1);

        // Request held high with inputs changing every cycle
        for (int f = 0; f < 6; f++)
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'd8, 1'b1, 1'b1, -1);
        ifc.Data_Valid = 1'b0;
        @(negedge clk);
        check_idle("hold_end");

        run_frame(8'h3C, 1'b1, 1'b0, 6'd32, 1'b0, 1'b0, 5 * 32 + 10);
        repeat (5) begin
            @(negedge clk);
            check_idle("post_abort");
        end
        run_frame(8'h3C, 1'b1, 1'b0, 6'd32, 1'b0, 1'b0, -1);

        // Reset and request on the same edge: reset wins
        rst = 1'b0;
        ifc.P_DATA = 8'h55;
        ifc.Data_Valid = 1'b1;
        @(negedge clk);
        check_idle("rst_vs_dv");
        rst = 1'b1;
        ifc.Data_Valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("rst_vs_dv_after");
        end

        run_frame(8'h96, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, -1);
        run_frame(8'hC3, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, -1);
        run_frame(8'hFF, 1'b1, 1'b0, 6'd63, 1'b0, 1'b0, -1);

        for (int n = 0; n < 256; n++)
            run_frame(8'($urandom), 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter that pairs with the existing UART receiver path, including its start, data, parity and stop checking. It accepts one parallel byte per handshake and serialises it onto TX_OUT as a frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. Each bit is held for Prescale clock cycles, so TX and RX share one Prescale setting and one system clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame (fixed at 8 for this release).
PRESCALE_WIDTH, 6, width of the Prescale input and of the internal bit-period counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-low reset.
P_DATA  input  8  parallel byte to transmit.
Data_Valid  input  1  request strobe; sampled only while busy=0.
PAR_EN  input  1  1 inserts a parity bit after the data bits.
PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
Prescale  input  6  clk cycles per serial bit.
TX_OUT  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: when rst=0 at a rising edge, TX_OUT<=1, busy<=0, state<=IDLE, and all counters and latches are cleared. Reset mid-frame abandons the frame, and the line returns high on that edge.
- Both outputs are registered. No combinational path runs from any input to TX_OUT or busy.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1 and busy=0. At an edge with Data_Valid=1, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale (value 0 is treated as 1). The next state is START.
- Acceptance edge: TX_OUT<=0 and busy<=1, so the start bit appears one cycle after the accepting edge.
- Data_Valid while busy=1 is ignored. The request is not queued. Input changes mid-frame have no effect because all frame fields are latched.
- Bit timing: a bit counter runs from 0 to P-1, where P is the latched Prescale. Every bit, including start, parity and stop, is held for exactly P cycles.
- START goes to DATA after P cycles.
- DATA shifts out the latched byte LSB first, bit index 0..7. After the 8th bit it goes to PARITY if the latched PAR_EN=1, otherwise to STOP.
- Parity is computed from the latched byte:
  - even: TX parity bit = XOR of the 8 bits;
  - odd: TX parity bit = inverted XOR of the 8 bits.
- STOP drives TX_OUT=1 for P cycles. At the edge ending the stop bit the block returns to IDLE, busy<=0 and TX_OUT stays 1.
- Frame length is P*10 cycles with no parity and P*11 cycles with parity. busy is high for exactly that many cycles.
- Back-to-back frames: Data_Valid can first be accepted on the edge after busy falls. The minimum gap between frames is therefore one idle-high cycle.
- Simultaneous rst=0 and Data_Valid=1: reset wins and no frame starts.
- Width rules:
  - the bit counter is PRESCALE_WIDTH bits; P max is 63 and the counter never wraps within a bit;
  - the data index is 3 bits and saturates, with the exit condition at index 7 plus counter at P-1.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then rst=1 with no Data_Valid for 50 cycles -> TX_OUT=1 and busy=0 throughout.
2. Prescale=8, PAR_EN=0, P_DATA=8'hA5, one-cycle Data_Valid pulse -> TX_OUT holds 0 for cycles 1-8 after acceptance, then bit sequence 1,0,1,0,0,1,0,1 with 8 cycles each, then 1 for 8 cycles; busy is high for exactly 80 cycles.
3. Prescale=16, PAR_EN=1, and P_DATA=8'h07 sent twice, first with PAR_TYP=0 then with PAR_TYP=1 -> parity bit is 1 for even and 0 for odd; each frame is 176 cycles.
4. Hold Data_Valid=1 continuously with P_DATA changing every cycle, Prescale=8 -> each frame carries the byte present at its own acceptance edge; exactly one idle-high cycle separates frames; data is never corrupted mid-frame.
5. Prescale=32, P_DATA=8'h3C, PAR_EN=1, with rst=0 asserted during data bit 4 -> on that edge TX_OUT=1 and busy=0; the next request sends a complete, correct frame.
6. Loopback to the receiver path with Prescale=8, PAR_EN=1, even parity and random bytes x256 -> every byte is recovered by the receiver with no parity or stop error.
